alu_issue_ctrl: RTL and testbench

//  Sequential issue/capture stage wrapped around the combinational ALU (alu).
//  - Accepts an operation request, then collects 16-bit operands serially over a valid/ready stream.
//  - Drives stable operands, mode and op into the ALU, waits a settle window, then registers both 32-bit results.
//  - Presents the registered results on a valid/ready output handshake.

---
 rtl/alu_issue_ctrl_if.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 113 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU-side bundle for alu_issue_ctrl: request, operand stream,
// ALU operand/result wiring and result handshake.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int RES_W  = 32
);
    logic              i_start;
    logic              i_mode;
    logic [3:0]        i_op;
    logic              o_busy;
    logic [DATA_W-1:0] i_data;
    logic              i_data_valid;
    logic              o_data_ready;
    logic              o_alu_mode;
    logic [3:0]        o_alu_op;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic [DATA_W-1:0] o_alu_c;
    logic [DATA_W-1:0] o_alu_d;
    logic [RES_W-1:0]  i_alu_out1;
    logic [RES_W-1:0]  i_alu_out2;
    logic [RES_W-1:0]  o_res1;
    logic [RES_W-1:0]  o_res2;
    logic              o_res_valid;
    logic              i_res_ready;
    logic              o_err;

    modport slave (
        input  i_start, i_mode, i_op, i_data, i_data_valid,
               i_alu_out1, i_alu_out2, i_res_ready,
        output o_busy, o_data_ready, o_alu_mode, o_alu_op,
               o_alu_a, o_alu_b, o_alu_c, o_alu_d,
               o_res1, o_res2, o_res_valid, o_err
    );

    modport master (
        output i_start, i_mode, i_op, i_data, i_data_valid,
               i_alu_out1, i_alu_out2, i_res_ready,
        input  o_busy, o_data_ready, o_alu_mode, o_alu_op,
               o_alu_a, o_alu_b, o_alu_c, o_alu_d,
               o_res1, o_res2, o_res_valid, o_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage around the combinational ALU: serial operand load,
// settle window, result capture and hold. Optional macro: ALU_ISSUE_ERR_EN.
module alu_issue_ctrl #(
    parameter int DATA_W      = 16,
    parameter int RES_W       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    alu_issue_ctrl_if.slave bus
);
    localparam int TMR_W = (EXEC_CYCLES < 2) ? 1 : $clog2(EXEC_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(EXEC_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_HOLD} state_t;

    state_t            state, state_nx;
    logic [1:0]        slot;
    logic [TMR_W-1:0]  timer;
    logic              accept;
    logic              last_word;
    logic              illegal_op;

    always_comb begin
        illegal_op = 1'b0;
`ifdef ALU_ISSUE_ERR_EN
        illegal_op = (bus.i_op > 4'd8);
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        bus.o_busy       = (state != S_IDLE);
        bus.o_data_ready = (state == S_LOAD);
        bus.o_res_valid  = (state == S_HOLD);
        accept           = (state == S_LOAD) && bus.i_data_valid;
        last_word        = (slot == (bus.o_alu_mode ? 2'd3 : 2'd1));
        unique case (state)
            S_IDLE: if (bus.i_start) state_nx = illegal_op ? S_HOLD : S_LOAD;
            S_LOAD: if (accept && last_word) state_nx = S_EXEC;
            S_EXEC: if (timer == TMR_ONE) state_nx = S_HOLD;
            S_HOLD: if (bus.i_res_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_alu_mode <= 1'b0;
            bus.o_alu_op   <= '0;
            bus.o_alu_a    <= '0;
            bus.o_alu_b    <= '0;
            bus.o_alu_c    <= '0;
            bus.o_alu_d    <= '0;
            bus.o_res1     <= '0;
            bus.o_res2     <= '0;
            slot           <= '0;
            timer          <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (bus.i_start) begin
                    bus.o_alu_mode <= bus.i_mode;
                    bus.o_alu_op   <= bus.i_op;
                    bus.o_alu_a    <= '0;
                    bus.o_alu_b    <= '0;
                    bus.o_alu_c    <= '0;
                    bus.o_alu_d    <= '0;
                    slot           <= '0;
                    // Illegal ops bypass EXEC, so the zero result is loaded here.
                    if (illegal_op) begin
                        bus.o_res1 <= '0;
                        bus.o_res2 <= '0;
                    end
                end
                S_LOAD: if (accept) begin
                    unique case (slot)
                        2'd0: bus.o_alu_a <= bus.i_data;
                        2'd1: bus.o_alu_b <= bus.i_data;
                        2'd2: bus.o_alu_c <= bus.i_data;
                        default: bus.o_alu_d <= bus.i_data;
                    endcase
                    slot <= slot + 2'd1;
                    if (last_word) timer <= TMR_INIT;
                end
                S_EXEC: begin
                    timer <= timer - TMR_ONE;
                    if (timer == TMR_ONE) begin
                        bus.o_res1 <= bus.i_alu_out1;
                        bus.o_res2 <= bus.i_alu_out2;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ISSUE_ERR_EN
    logic err_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                err_q <= 1'b0;
        else if (state == S_IDLE && bus.i_start) err_q <= illegal_op;
    end
    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU stand-in and
// a result scoreboard.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DATA_W(16), .RES_W(32)) bus ();
    alu_issue_ctrl_if #(.DATA_W(16), .RES_W(32)) bus3 ();

    alu_issue_ctrl #(.DATA_W(16), .RES_W(32), .EXEC_CYCLES(1)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus.slave));
    alu_issue_ctrl #(.DATA_W(16), .RES_W(32), .EXEC_CYCLES(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .bus(bus3.slave));

    // Behavioural stand-in for the external ALU; unknown opcodes yield zero.
    function automatic logic [31:0] alu1(input logic m, input logic [3:0] op,
                                         input logic [15:0] a, b, c, d);
        logic [31:0] x, y, r;
        logic [4:0]  s;
        x = m ? 32'(a) + 32'(c) : 32'(a);
        y = m ? 32'(b) + 32'(d) : 32'(b);
        s = y[4:0];
        case (op)
            4'd0: r = x + y;
            4'd1: r = x - y;
            4'd2: r = x << s;
            4'd3: r = x >> s;
            4'd4: r = $unsigned($signed(x) >>> s);
            4'd5: r = (x << s) | (x >> (6'd32 - 6'(s)));
            4'd6: r = (x >> s) | (x << (6'd32 - 6'(s)));
            4'd7: r = x * y;
            4'd8: r = (y != 0) ? x / y : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] alu2(input logic [3:0] op,
                                         input logic [15:0] a, b, c, d);
        return (op <= 4'd8) ? ({d, c} ^ {a, b}) : 32'd0;
    endfunction

    assign bus.i_alu_out1  = alu1(bus.o_alu_mode, bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, bus.o_alu_c, bus.o_alu_d);
    assign bus.i_alu_out2  = alu2(bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, bus.o_alu_c, bus.o_alu_d);
    assign bus3.i_alu_out1 = alu1(bus3.o_alu_mode, bus3.o_alu_op, bus3.o_alu_a, bus3.o_alu_b, bus3.o_alu_c, bus3.o_alu_d);
    assign bus3.i_alu_out2 = alu2(bus3.o_alu_op, bus3.o_alu_a, bus3.o_alu_b, bus3.o_alu_c, bus3.o_alu_d);

    task automatic do_start(input logic m, input logic [3:0] op);
        bus.i_start = 1'b1; bus.i_mode = m; bus.i_op = op;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        bus.i_data = w; bus.i_data_valid = 1'b1;
        @(negedge clk);
        bus.i_data_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.o_res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_result();
        bus.i_res_ready = 1'b1;
        @(negedge clk);
        bus.i_res_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.o_busy); else n_pass++;
        n_checks++; if (bus.o_data_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.o_data_ready); else n_pass++;
        n_checks++; if (bus.o_res_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.o_res_valid); else n_pass++;
        n_checks++; if ({bus.o_res1, bus.o_res2} !== 64'd0) $display("FAIL reset_res: got %h expected 0", {bus.o_res1, bus.o_res2}); else n_pass++;
        n_checks++; if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_c, bus.o_alu_d} !== 64'd0) $display("FAIL reset_alu_ops: got %h expected 0", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_c, bus.o_alu_d}); else n_pass++;
        n_checks++; if (bus.o_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus.o_err); else n_pass++;
    endtask

    task automatic test_simple_add();
        logic [63:0] exp;
        sb_q.push_back({alu1(1'b0, 4'd0, 16'd3, 16'd4, 16'd0, 16'd0), alu2(4'd0, 16'd3, 16'd4, 16'd0, 16'd0)});
        do_start(1'b0, 4'd0);
        n_checks++; if (bus.o_data_ready !== 1'b1) $display("FAIL add_ready: got %b expected 1", bus.o_data_ready); else n_pass++;
        send_word(16'h0003);
        send_word(16'h0004);
        n_checks++; if (bus.o_res_valid !== 1'b0) $display("FAIL add_valid_t2: got %b expected 0", bus.o_res_valid); else n_pass++;
        n_checks++; if (bus.o_busy !== 1'b1) $display("FAIL add_busy_exec: got %b expected 1", bus.o_busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.o_res_valid !== 1'b1) $display("FAIL add_valid_t3: got %b expected 1", bus.o_res_valid); else n_pass++;
        exp = sb_q.pop_front();
        n_checks++; if ({bus.o_res1, bus.o_res2} !== exp) $display("FAIL add_result: got %h expected %h", {bus.o_res1, bus.o_res2}, exp); else n_pass++;
        release_result();
        n_checks++; if (bus.o_res_valid !== 1'b0 || bus.o_busy !== 1'b0) $display("FAIL add_idle: got valid=%b busy=%b expected 0 0", bus.o_res_valid, bus.o_busy); else n_pass++;
        n_checks++; if ({bus.o_res1, bus.o_res2} !== exp) $display("FAIL add_res_kept: got %h expected %h", {bus.o_res1, bus.o_res2}, exp); else n_pass++;
    endtask

    task automatic test_stall_mul();
        int n;
        logic [63:0] exp;
        sb_q.push_back({alu1(1'b1, 4'd7, 16'd2, 16'd3, 16'd4, 16'd5), alu2(4'd7, 16'd2, 16'd3, 16'd4, 16'd5)});
        do_start(1'b1, 4'd7);
        send_word(16'd2);
        send_word(16'd3);
        repeat (2) begin
            @(negedge clk);
            n_checks++; if (bus.o_data_ready !== 1'b1 || bus.o_alu_b !== 16'd3 || bus.o_alu_c !== 16'd0) $display("FAIL stall_hold: got ready=%b b=%h c=%h expected 1 0003 0000", bus.o_data_ready, bus.o_alu_b, bus.o_alu_c); else n_pass++;
        end
        send_word(16'd4);
        send_word(16'd5);
        wait_valid(n);
        n_checks++; if (n + 6 !== 7) $display("FAIL stall_latency: got %0d expected 7", n + 6); else n_pass++;
        n_checks++; if (bus.o_alu_c !== 16'd4 || bus.o_alu_d !== 16'd5) $display("FAIL stall_cd: got c=%h d=%h expected 0004 0005", bus.o_alu_c, bus.o_alu_d); else n_pass++;
        exp = sb_q.pop_front();
        n_checks++; if ({bus.o_res1, bus.o_res2} !== exp) $display("FAIL stall_result: got %h expected %h", {bus.o_res1, bus.o_res2}, exp); else n_pass++;
        sb_q.push_back(exp);
    endtask

    task automatic test_hold_backpressure();
        logic [63:0] exp;
        exp = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin bus.i_start = 1'b1; bus.i_op = 4'd1; bus.i_mode = 1'b0; end
            @(negedge clk);
            bus.i_start = 1'b0;
            n_checks++; if (bus.o_res_valid !== 1'b1 || {bus.o_res1, bus.o_res2} !== exp || bus.o_alu_op !== 4'd7) $display("FAIL hold_stable: got valid=%b res=%h op=%h expected 1 %h 7", bus.o_res_valid, {bus.o_res1, bus.o_res2}, bus.o_alu_op, exp); else n_pass++;
        end
        bus.i_start = 1'b1;
        release_result();
        bus.i_start = 1'b0;
        n_checks++; if (bus.o_busy !== 1'b0 || bus.o_res_valid !== 1'b0) $display("FAIL hold_exit_idle: got busy=%b valid=%b expected 0 0", bus.o_busy, bus.o_res_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL hold_start_ignored: got busy=%b expected 0", bus.o_busy); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        do_start(1'b1, 4'd0);
        send_word(16'hAAAA);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.o_busy !== 1'b0 || bus.o_data_ready !== 1'b0 || bus.o_res_valid !== 1'b0) $display("FAIL rst_async_ctrl: got busy=%b ready=%b valid=%b expected 0 0 0", bus.o_busy, bus.o_data_ready, bus.o_res_valid); else n_pass++;
        n_checks++; if ({bus.o_alu_mode, bus.o_alu_op, bus.o_alu_a, bus.o_alu_b} !== 37'd0) $display("FAIL rst_async_alu: got %h expected 0", {bus.o_alu_mode, bus.o_alu_op, bus.o_alu_a, bus.o_alu_b}); else n_pass++;
        n_checks++; if ({bus.o_res1, bus.o_res2, bus.o_err} !== 65'd0) $display("FAIL rst_async_res: got %h expected 0", {bus.o_res1, bus.o_res2, bus.o_err}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.o_busy !== 1'b0 || bus.o_res_valid !== 1'b0) $display("FAIL rst_after: got busy=%b valid=%b expected 0 0", bus.o_busy, bus.o_res_valid); else n_pass++;
    endtask

    task automatic test_illegal_op();
`ifdef ALU_ISSUE_ERR_EN
        do_start(1'b0, 4'd12);
        n_checks++; if (bus.o_res_valid !== 1'b1 || bus.o_err !== 1'b1) $display("FAIL illegal_hold: got valid=%b err=%b expected 1 1", bus.o_res_valid, bus.o_err); else n_pass++;
        n_checks++; if ({bus.o_res1, bus.o_res2} !== 64'd0) $display("FAIL illegal_res: got %h expected 0", {bus.o_res1, bus.o_res2}); else n_pass++;
        release_result();
        do_start(1'b0, 4'd0);
        n_checks++; if (bus.o_err !== 1'b0) $display("FAIL illegal_err_clear: got %b expected 0", bus.o_err); else n_pass++;
        send_word(16'd1);
        send_word(16'd1);
        @(negedge clk);
        release_result();
`else
        int n;
        logic [63:0] exp;
        sb_q.push_back(64'd0);
`endif
    endtask

    task automatic test_illegal_op_flow();
        int n;
        logic [63:0] exp;
        sb_q.push_back({alu1(1'b0, 4'd12, 16'd5, 16'd6, 16'd0, 16'd0), alu2(4'd12, 16'd5, 16'd6, 16'd0, 16'd0)});
        do_start(1'b0, 4'd12);
        n_checks++; if (bus.o_data_ready !== 1'b1) $display("FAIL illegal_load: got ready=%b expected 1", bus.o_data_ready); else n_pass++;
        send_word(16'd5);
        send_word(16'd6);
        wait_valid(n);
        n_checks++; if (n !== 1) $display("FAIL illegal_latency: got %0d expected 1", n); else n_pass++;
        exp = sb_q.pop_front();
        n_checks++; if ({bus.o_res1, bus.o_res2} !== exp || bus.o_err !== 1'b0) $display("FAIL illegal_res: got %h err=%b expected %h 0", {bus.o_res1, bus.o_res2}, bus.o_err, exp); else n_pass++;
        release_result();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [63:0] exp;
        logic        m;
        logic [3:0]  op;
        logic [15:0] w[4];
        for (int k = 0; k < 4; k++) begin
            m  = 1'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 8));
            for (int j = 0; j < 4; j++) w[j] = (m || j < 2) ? 16'($urandom) : 16'd0;
            sb_q.push_back({alu1(m, op, w[0], w[1], w[2], w[3]), alu2(op, w[0], w[1], w[2], w[3])});
            do_start(m, op);
            for (int j = 0; j < (m ? 4 : 2); j++) send_word(w[j]);
            wait_valid(n);
            n_checks++; if (n !== 1) $display("FAIL b2b_latency[%0d]: got %0d expected 1", k, n); else n_pass++;
            exp = sb_q.pop_front();
            n_checks++; if ({bus.o_res1, bus.o_res2} !== exp) $display("FAIL b2b_result[%0d]: got %h expected %h", k, {bus.o_res1, bus.o_res2}, exp); else n_pass++;
            release_result();
        end
    endtask

    task automatic test_exec3_sub();
        int n;
        logic [63:0] exp;
        logic [36:0] alu_snap;
        sb_q.push_back({alu1(1'b0, 4'd1, 16'd10, 16'd3, 16'd0, 16'd0), alu2(4'd1, 16'd10, 16'd3, 16'd0, 16'd0)});
        bus3.i_start = 1'b1; bus3.i_mode = 1'b0; bus3.i_op = 4'd1;
        @(negedge clk);
        bus3.i_start = 1'b0;
        bus3.i_data = 16'd10; bus3.i_data_valid = 1'b1;
        @(negedge clk);
        bus3.i_data = 16'd3;
        @(negedge clk);
        bus3.i_data_valid = 1'b0;
        alu_snap = {bus3.o_alu_mode, bus3.o_alu_op, bus3.o_alu_a, bus3.o_alu_b};
        n = 0;
        while (!bus3.o_res_valid && n < 40) begin
            @(negedge clk);
            n++;
            n_checks++; if ({bus3.o_alu_mode, bus3.o_alu_op, bus3.o_alu_a, bus3.o_alu_b} !== 37'h0_1_000A_0003) $display("FAIL exec3_alu_stable: got %h expected %h", {bus3.o_alu_mode, bus3.o_alu_op, bus3.o_alu_a, bus3.o_alu_b}, 37'h0_1_000A_0003); else n_pass++;
        end
        n_checks++; if (n !== 3) $display("FAIL exec3_latency: got %0d expected 3", n); else n_pass++;
        exp = sb_q.pop_front();
        n_checks++; if ({bus3.o_res1, bus3.o_res2} !== exp) $display("FAIL exec3_result: got %h expected %h", {bus3.o_res1, bus3.o_res2}, exp); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if ({bus3.o_alu_mode, bus3.o_alu_op, bus3.o_alu_a, bus3.o_alu_b} !== alu_snap || bus3.o_res_valid !== 1'b1) $display("FAIL exec3_hold_stable: got %h valid=%b expected %h 1", {bus3.o_alu_mode, bus3.o_alu_op, bus3.o_alu_a, bus3.o_alu_b}, bus3.o_res_valid, alu_snap); else n_pass++;
        bus3.i_res_ready = 1'b1;
        @(negedge clk);
        bus3.i_res_ready = 1'b0;
        n_checks++; if (bus3.o_busy !== 1'b0) $display("FAIL exec3_idle: got busy=%b expected 0", bus3.o_busy); else n_pass++;
    endtask

    initial begin
        bus.i_start = 1'b0;  bus.i_mode = 1'b0;  bus.i_op = 4'd0;
        bus.i_data = 16'd0;  bus.i_data_valid = 1'b0; bus.i_res_ready = 1'b0;
        bus3.i_start = 1'b0; bus3.i_mode = 1'b0; bus3.i_op = 4'd0;
        bus3.i_data = 16'd0; bus3.i_data_valid = 1'b0; bus3.i_res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_simple_add();
        test_stall_mul();
        test_hold_backpressure();
        test_reset_mid_load();
`ifdef ALU_ISSUE_ERR_EN
        test_illegal_op();
`else
        test_illegal_op_flow();
`endif
        test_back_to_back();
        test_exec3_sub();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
